// File: rtl/ap_txn_pkg.sv
// Shared types and defaults for the ap_ctrl_hs transaction tracker.
package ap_txn_pkg;

    localparam int unsigned TS_W_DEF = 32;
    localparam int unsigned ID_W_DEF = 16;

    // One latency record at the default widths.
    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [TS_W_DEF-1:0] start_ts;
        logic [TS_W_DEF-1:0] done_ts;
        logic [TS_W_DEF-1:0] latency;
    } txn_rec_t;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous timestamp FIFO with simultaneous push/pop and occupancy count.
module ts_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (r_count == CntFull);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Storage array; contents are don't-care once pointers reset.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ap_txn_tracker.sv
// Watches an ap_ctrl_hs handshake and emits one latency record per transaction.
module ap_txn_tracker
    import ap_txn_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned ID_W  = ID_W_DEF,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic                   ap_ready,
    input  logic                   ap_done,
    input  logic                   ap_continue,
    input  logic                   finish,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [ID_W-1:0]        rec_id,
    output logic [TS_W-1:0]        rec_start_ts,
    output logic [TS_W-1:0]        rec_done_ts,
    output logic [TS_W-1:0]        rec_latency,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   overflow,
    output logic                   orphan,
    output logic                   drained
);

    logic [TS_W-1:0]        r_cyc;
    logic [ID_W-1:0]        r_id;
    logic                   r_fin;
    logic                   r_valid;
    logic [ID_W-1:0]        r_rec_id;
    logic [TS_W-1:0]        r_rec_start;
    logic [TS_W-1:0]        r_rec_done;
    logic [TS_W-1:0]        r_rec_lat;
    logic                   r_overflow;
    logic                   r_orphan;

    logic                   w_start_ev;
    logic                   w_done_ev;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_have;
    logic                   w_out_free;
    logic                   w_load;
    logic                   w_drop_rec;
    logic                   w_drop_start;
    logic                   w_orphan_ev;
    logic [TS_W-1:0]        w_fifo_rdata;
    logic [TS_W-1:0]        w_start_ts;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;

    // Event decode; once finish has latched, the handshake is no longer observed.
    assign w_start_ev   = ap_start & ap_ready & ~r_fin;
    assign w_done_ev    = ap_done & ap_continue & ~r_fin;
    // Zero-latency transaction: pair the start directly with its own done.
    assign w_bypass     = w_start_ev & w_done_ev & w_empty;
    assign w_push       = w_start_ev & ~w_bypass & (~w_full | w_done_ev);
    assign w_pop        = w_done_ev & ~w_empty;
    assign w_have       = w_pop | w_bypass;
    assign w_drop_start = w_start_ev & w_full & ~w_done_ev;
    assign w_orphan_ev  = w_done_ev & w_empty & ~w_start_ev;
    assign w_out_free   = ~r_valid | rec_ready;
    assign w_load       = w_have & w_out_free;
    assign w_drop_rec   = w_have & ~w_out_free;
    assign w_start_ts   = w_bypass ? r_cyc : w_fifo_rdata;

    ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_cyc),
        .rdata (w_fifo_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Free-running cycle counter, finish latch and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cyc      <= '0;
            r_fin      <= 1'b0;
            r_overflow <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            r_cyc <= r_cyc + TS_W'(1);
            if (finish) begin
                r_fin <= 1'b1;
            end
            if (w_drop_start || w_drop_rec) begin
                r_overflow <= 1'b1;
            end
            if (w_orphan_ev) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // Transaction numbering advances for every paired done, even if its record is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id <= '0;
        end else if (w_have) begin
            r_id <= r_id + ID_W'(1);
        end
    end

    // Single-entry output register; may reload in the cycle it drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_rec_id    <= '0;
            r_rec_start <= '0;
            r_rec_done  <= '0;
            r_rec_lat   <= '0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_rec_id    <= r_id;
            r_rec_start <= w_start_ts;
            r_rec_done  <= r_cyc;
            r_rec_lat   <= r_cyc - w_start_ts;
        end else if (rec_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rec_valid    = r_valid;
    assign rec_id       = r_rec_id;
    assign rec_start_ts = r_rec_start;
    assign rec_done_ts  = r_rec_done;
    assign rec_latency  = r_rec_lat;
    assign outstanding  = w_count;
    assign overflow     = r_overflow;
    assign orphan       = r_orphan;
    assign drained      = r_fin & (w_count == '0) & ~r_valid;

endmodule

// File: tb/tb_ap_txn_tracker.sv
// Scoreboard bench for ap_txn_tracker, with a narrow-timestamp instance for wrap checks.
module tb_ap_txn_tracker;
    import ap_txn_pkg::*;

    logic        clock;
    logic        reset;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        finish;
    logic        rec_ready;

    logic        rec_valid;
    logic [15:0] rec_id;
    logic [31:0] rec_start_ts;
    logic [31:0] rec_done_ts;
    logic [31:0] rec_latency;
    logic [3:0]  outstanding;
    logic        overflow;
    logic        orphan;
    logic        drained;

    logic        w2_rec_valid;
    logic [15:0] w2_rec_id;
    logic [3:0]  w2_rec_start_ts;
    logic [3:0]  w2_rec_done_ts;
    logic [3:0]  w2_rec_latency;
    logic [3:0]  w2_outstanding;
    logic        w2_overflow;
    logic        w2_orphan;
    logic        w2_drained;

    txn_rec_t    sb[$];
    txn_rec_t    mon_exp;
    int          n_vec;
    int          n_err;
    int          tb_cyc;

    ap_txn_tracker #(
        .TS_W  (32),
        .ID_W  (16),
        .DEPTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_start_ts (rec_start_ts),
        .rec_done_ts  (rec_done_ts),
        .rec_latency  (rec_latency),
        .outstanding  (outstanding),
        .overflow     (overflow),
        .orphan       (orphan),
        .drained      (drained)
    );

    ap_txn_tracker #(
        .TS_W  (4),
        .ID_W  (16),
        .DEPTH (8)
    ) dut_w4 (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .rec_valid    (w2_rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (w2_rec_id),
        .rec_start_ts (w2_rec_start_ts),
        .rec_done_ts  (w2_rec_done_ts),
        .rec_latency  (w2_rec_latency),
        .outstanding  (w2_outstanding),
        .overflow     (w2_overflow),
        .orphan       (w2_orphan),
        .drained      (w2_drained)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle count: 0 in the first cycle after reset release.
    always @(posedge clock or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    // Scoreboard: every accepted record must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && rec_valid && rec_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rec_unexpected: got id=%0d start=%0d done=%0d lat=%0d, required no record",
                         rec_id, rec_start_ts, rec_done_ts, rec_latency);
            end else begin
                mon_exp = sb.pop_front();
                if (rec_id !== mon_exp.id || rec_start_ts !== mon_exp.start_ts ||
                    rec_done_ts !== mon_exp.done_ts || rec_latency !== mon_exp.latency) begin
                    n_err++;
                    $display("FAIL rec_data: got id=%0d start=%0d done=%0d lat=%0d, required id=%0d start=%0d done=%0d lat=%0d",
                             rec_id, rec_start_ts, rec_done_ts, rec_latency,
                             mon_exp.id, mon_exp.start_ts, mon_exp.done_ts, mon_exp.latency);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic txn_rec_t mk(input int id, input int s, input int d, input int l);
        txn_rec_t r;
        r.id       = 16'(id);
        r.start_ts = 32'(s);
        r.done_ts  = 32'(d);
        r.latency  = 32'(l);
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_to(input int c);
        while (tb_cyc < c) step();
    endtask

    task automatic do_reset();
        ap_start    = 1'b0;
        ap_ready    = 1'b1;
        ap_done     = 1'b0;
        ap_continue = 1'b1;
        finish      = 1'b0;
        rec_ready   = 1'b1;
        reset       = 1'b1;
        sb.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({rec_valid, overflow, orphan, drained} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got valid/ovf/orph/drn=%b, required 0000",
                     {rec_valid, overflow, orphan, drained});
        end
        n_vec++;
        if (outstanding !== 4'd0) begin
            n_err++;
            $display("FAIL reset_outstanding: got %0d, required 0", outstanding);
        end
        n_vec++;
        if (rec_id !== 16'd0 || rec_start_ts !== 32'd0 || rec_done_ts !== 32'd0 ||
            rec_latency !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got id=%0d start=%0d done=%0d lat=%0d, required all 0",
                     rec_id, rec_start_ts, rec_done_ts, rec_latency);
        end
    endtask

    task automatic test_single();
        do_reset();
        idle_to(5);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        n_vec++;
        if (outstanding !== 4'd1) begin
            n_err++;
            $display("FAIL single_outstanding: got %0d, required 1", outstanding);
        end
        idle_to(9);
        sb.push_back(mk(0, 5, 9, 4));
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        n_vec++;
        if (rec_valid !== 1'b1 || tb_cyc != 10) begin
            n_err++;
            $display("FAIL single_valid: got valid=%b at cyc %0d, required 1 at cyc 10",
                     rec_valid, tb_cyc);
        end
        step();
        n_vec++;
        if (rec_valid !== 1'b0 || outstanding !== 4'd0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL single_after: got valid=%b outst=%0d pending=%0d, required 0 0 0",
                     rec_valid, outstanding, sb.size());
        end
    endtask

    task automatic test_pipeline();
        int peak;
        peak = 0;
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            ap_start = (c >= 3 && c <= 10);
            ap_done  = (c >= 9 && c <= 16);
            if (ap_done) sb.push_back(mk(c - 9, c - 6, c, 6));
            step();
            if (int'(outstanding) > peak) peak = int'(outstanding);
        end
        ap_start = 1'b0;
        ap_done  = 1'b0;
        step();
        n_vec++;
        if (peak != 6) begin
            n_err++;
            $display("FAIL pipe_peak: got %0d, required 6", peak);
        end
        n_vec++;
        if (overflow !== 1'b0 || orphan !== 1'b0 || outstanding !== 4'd0) begin
            n_err++;
            $display("FAIL pipe_flags: got ovf=%b orph=%b outst=%0d, required 0 0 0",
                     overflow, orphan, outstanding);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pipe_count: got %0d records missing, required 0", sb.size());
        end
    endtask

    task automatic test_zero();
        do_reset();
        idle_to(4);
        ap_start = 1'b1;
        ap_done  = 1'b1;
        sb.push_back(mk(0, 4, 4, 0));
        step();
        ap_start = 1'b0;
        ap_done  = 1'b0;
        n_vec++;
        if (rec_valid !== 1'b1 || orphan !== 1'b0 || outstanding !== 4'd0) begin
            n_err++;
            $display("FAIL zero_flags: got valid=%b orph=%b outst=%0d, required 1 0 0",
                     rec_valid, orphan, outstanding);
        end
        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL zero_record: got %0d records missing, required 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            ap_start = 1'b1;
            step();
            if (c == 7) begin
                n_vec++;
                if (overflow !== 1'b0 || outstanding !== 4'd8) begin
                    n_err++;
                    $display("FAIL ovf_full: got ovf=%b outst=%0d, required 0 8",
                             overflow, outstanding);
                end
            end
        end
        ap_start = 1'b0;
        n_vec++;
        if (overflow !== 1'b1 || outstanding !== 4'd8 || rec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_drop: got ovf=%b outst=%0d valid=%b, required 1 8 0",
                     overflow, outstanding, rec_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rec_ready = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            ap_start = (c == 1 || c == 2);
            ap_done  = (c == 3 || c == 4);
            step();
            if (c == 3) begin
                n_vec++;
                if (overflow !== 1'b0 || rec_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_first: got ovf=%b valid=%b, required 0 1",
                             overflow, rec_valid);
                end
            end
        end
        ap_start = 1'b0;
        ap_done  = 1'b0;
        n_vec++;
        if (overflow !== 1'b1 || outstanding !== 4'd0) begin
            n_err++;
            $display("FAIL bp_drop: got ovf=%b outst=%0d, required 1 0", overflow, outstanding);
        end
        step();
        n_vec++;
        if (rec_valid !== 1'b1 || rec_id !== 16'd0 || rec_start_ts !== 32'd1 ||
            rec_done_ts !== 32'd3 || rec_latency !== 32'd2) begin
            n_err++;
            $display("FAIL bp_hold: got valid=%b id=%0d start=%0d done=%0d lat=%0d, required 1 0 1 3 2",
                     rec_valid, rec_id, rec_start_ts, rec_done_ts, rec_latency);
        end
        sb.push_back(mk(0, 1, 3, 2));
        rec_ready = 1'b1;
        step();
        n_vec++;
        if (rec_valid !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got valid=%b pending=%0d, required 0 0", rec_valid, sb.size());
        end
    endtask

    task automatic test_orphan();
        do_reset();
        idle_to(2);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        n_vec++;
        if (orphan !== 1'b1 || rec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL orphan_flag: got orph=%b valid=%b, required 1 0", orphan, rec_valid);
        end
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        idle_to(5);
        // The orphan done must not have consumed a transaction number.
        sb.push_back(mk(0, 3, 5, 2));
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        step();
        n_vec++;
        if (sb.size() != 0 || orphan !== 1'b1) begin
            n_err++;
            $display("FAIL orphan_next: got pending=%0d orph=%b, required 0 1", sb.size(), orphan);
        end
    endtask

    task automatic test_finish();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            ap_start = (c == 1 || c == 2 || c == 4);
            finish   = (c == 3);
            ap_done  = (c == 4 || c == 5);
            step();
        end
        ap_start = 1'b0;
        ap_done  = 1'b0;
        step();
        n_vec++;
        if (outstanding !== 4'd2 || rec_valid !== 1'b0 || drained !== 1'b0) begin
            n_err++;
            $display("FAIL fin_ignore: got outst=%0d valid=%b drn=%b, required 2 0 0",
                     outstanding, rec_valid, drained);
        end
        do_reset();
        finish = 1'b1;
        step();
        finish = 1'b0;
        n_vec++;
        if (drained !== 1'b1) begin
            n_err++;
            $display("FAIL fin_drained: got %b, required 1", drained);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        idle_to(14);
        ap_start = 1'b1;
        sb.push_back(mk(0, 14, 17, 3));
        step();
        ap_start = 1'b0;
        idle_to(17);
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        n_vec++;
        if (w2_rec_valid !== 1'b1 || w2_rec_start_ts !== 4'd14 || w2_rec_done_ts !== 4'd1 ||
            w2_rec_latency !== 4'd3) begin
            n_err++;
            $display("FAIL wrap_rec: got valid=%b start=%0d done=%0d lat=%0d, required 1 14 1 3",
                     w2_rec_valid, w2_rec_start_ts, w2_rec_done_ts, w2_rec_latency);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rec_ready = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            ap_start = (c == 1 || c == 2);
            ap_done  = (c == 3);
            step();
        end
        ap_start = 1'b0;
        ap_done  = 1'b0;
        n_vec++;
        if (rec_valid !== 1'b1 || outstanding !== 4'd1) begin
            n_err++;
            $display("FAIL rstmid_pre: got valid=%b outst=%0d, required 1 1", rec_valid, outstanding);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({rec_valid, overflow, orphan, drained} !== 4'b0000 || outstanding !== 4'd0 ||
            rec_id !== 16'd0 || rec_start_ts !== 32'd0 || rec_done_ts !== 32'd0 ||
            rec_latency !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_clear: got valid=%b outst=%0d start=%0d done=%0d lat=%0d, required all 0",
                     rec_valid, outstanding, rec_start_ts, rec_done_ts, rec_latency);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        rec_ready = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_pipeline();
        test_zero();
        test_overflow();
        test_backpressure();
        test_orphan();
        test_finish();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
